// File: rtl/trig_pkg.sv
// Shared trigger-link definitions: sync byte, frame types, framer states and header layout.
// The trigger link decoder uses the same header field offsets.
package trig_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef logic [1:0] frame_type_t;
  localparam frame_type_t FRAME_RESULT    = 2'b00;
  localparam frame_type_t FRAME_HEARTBEAT = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_HDR,
    ST_TS,
    ST_PAY,
    ST_TRL
  } frame_state_e;

  localparam int HDR_SYNC_LSB = 24;
  localparam int HDR_TYPE_LSB = 22;
  localparam int HDR_FLAG_BIT = 21;
  localparam int HDR_FCNT_LSB = 0;

  function automatic logic [31:0] make_header(input frame_type_t typ, input logic flag,
                                              input logic [15:0] fcnt);
    logic [31:0] h;
    h = '0;
    h[HDR_SYNC_LSB +: 8] = SYNC_BYTE;
    h[HDR_TYPE_LSB +: 2] = typ;
    h[HDR_FLAG_BIT]      = flag;
    h[HDR_FCNT_LSB +: 16] = fcnt;
    return h;
  endfunction

endpackage

// File: rtl/trig_result_framer.sv
// Wraps each trigger result (or an idle heartbeat) into a 4-word frame; rden to header is 2 cycles.
// Words are held until out_ready; the FIFO is only read from IDLE, so backpressure stalls the FIFO.
module trig_result_framer
  import trig_pkg::*;
#(
  parameter logic signed [31:0] SUM_LIMIT = 32'sd0,
  parameter int unsigned        HB_PERIOD = 1000,
  parameter int unsigned        FCNT_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rdfifo_dat,
  input  logic        rdfifo_empty,
  output logic        rdfifo_rden,
  output logic [31:0] out_dat,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy
);

  frame_state_e      state_q, state_d;
  logic [31:0]       ts_q;
  logic [31:0]       ts_lat_q;
  logic [31:0]       pay_q;
  frame_type_t       type_q;
  logic              flag_q;
  logic [FCNT_W-1:0] fcnt_q;
  logic [31:0]       hb_q;

  logic              hb_expire;
  logic              rden_c;
  logic [31:0]       hdr_w;
  logic [31:0]       trl_w;

  assign hb_expire = (HB_PERIOD != 0) && (hb_q == HB_PERIOD - 1);
  assign hdr_w     = make_header(type_q, flag_q, 16'(fcnt_q));
  assign trl_w     = hdr_w ^ ts_lat_q ^ pay_q;
  assign busy      = (state_q != ST_IDLE);
  // A read during the reset cycle would lose a result, so rden is gated by rst.
  assign rdfifo_rden = rden_c & ~rst;

  always_comb begin
    state_d   = state_q;
    rden_c    = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_dat   = '0;
    case (state_q)
      ST_IDLE: begin
        if (!rdfifo_empty) begin
          rden_c  = 1'b1;
          state_d = ST_RD_WAIT;
        end else if (hb_expire) begin
          state_d = ST_HDR;
        end
      end
      ST_RD_WAIT: state_d = ST_HDR;
      ST_HDR: begin
        out_valid = 1'b1;
        out_dat   = hdr_w;
        if (out_ready) state_d = ST_TS;
      end
      ST_TS: begin
        out_valid = 1'b1;
        out_dat   = ts_lat_q;
        if (out_ready) state_d = ST_PAY;
      end
      ST_PAY: begin
        out_valid = 1'b1;
        out_dat   = pay_q;
        if (out_ready) state_d = ST_TRL;
      end
      ST_TRL: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_dat   = trl_w;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ts_q     <= '0;
      ts_lat_q <= '0;
      pay_q    <= '0;
      type_q   <= FRAME_RESULT;
      flag_q   <= 1'b0;
      fcnt_q   <= '0;
      hb_q     <= '0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_q + 32'd1;
      if (state_q == ST_IDLE) begin
        // A pending result takes priority over an expiring heartbeat.
        if (!rdfifo_empty) begin
          ts_lat_q <= ts_q;
          hb_q     <= '0;
        end else if (hb_expire) begin
          ts_lat_q <= ts_q;
          pay_q    <= '0;
          type_q   <= FRAME_HEARTBEAT;
          flag_q   <= 1'b0;
          hb_q     <= '0;
        end else begin
          hb_q <= hb_q + 32'd1;
        end
      end
      if (state_q == ST_RD_WAIT) begin
        pay_q  <= rdfifo_dat;
        type_q <= FRAME_RESULT;
        flag_q <= ($signed(rdfifo_dat) > SUM_LIMIT);
      end
      if (state_q == ST_TRL && out_ready) fcnt_q <= fcnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_trig_result_framer.sv
// Self-checking bench for trig_result_framer: FIFO model driven from the test thread,
// frame words collected by a negedge monitor and compared with a frame-rule model.
module tb_trig_result_framer;

  localparam int HBP = 100;
  localparam int FW  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] rdfifo_dat = '0;
  logic        rdfifo_empty = 1'b1;
  logic        rdfifo_rden;
  logic [31:0] out_dat;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic        busy;

  always #5 clk = ~clk;

  trig_result_framer #(
    .SUM_LIMIT(32'sd0),
    .HB_PERIOD(HBP),
    .FCNT_W   (FW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rdfifo_dat  (rdfifo_dat),
    .rdfifo_empty(rdfifo_empty),
    .rdfifo_rden (rdfifo_rden),
    .out_dat     (out_dat),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy)
  );

  int vecs = 0;
  int errs = 0;
  int cyc;
  int m_fc;
  int rd_ptr = 0;
  bit rnd_mode = 1'b0;

  logic [31:0] fq[$];
  logic [31:0] words[$];
  logic        lasts[$];
  int          wcyc[$];
  int          rden_cyc[$];
  logic        rd_pend = 1'b0;
  int          viol = 0;

  logic [31:0] fw[4];
  logic        fl[4];
  int          fcy[4];

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    rd_pend = rdfifo_rden;
    if (!rst) begin
      if (rdfifo_rden) begin
        rden_cyc.push_back(cyc);
        if (busy) viol++;
      end
      if (out_valid && out_ready) begin
        words.push_back(out_dat);
        lasts.push_back(out_last);
        wcyc.push_back(cyc);
      end
      if (out_last && !out_valid) viol++;
    end
  end

  // Frame rules: header = A5 | type | flag | 5'b0 | counter, trailer = XOR of the rest.
  function automatic logic [31:0] exp_word(int i, logic [1:0] typ, logic [31:0] pay,
                                           logic [31:0] ts, int fc);
    logic        flag;
    logic [31:0] hdr;
    flag = (typ == 2'b00) && ($signed(pay) > 0);
    hdr  = {8'hA5, typ, flag, 5'b00000, 16'(fc % (1 << FW))};
    case (i)
      0:       return hdr;
      1:       return ts;
      2:       return pay;
      default: return hdr ^ ts ^ pay;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rd_pend && fq.size() > 0) rdfifo_dat = fq.pop_front();
    rdfifo_empty = (fq.size() == 0);
    if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic push(input logic [31:0] v);
    fq.push_back(v);
    rdfifo_empty = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rnd_mode = 1'b0;
    out_ready = 1'b1;
    fq.delete();
    rdfifo_empty = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    m_fc = 0;
    rd_ptr = words.size();
  endtask

  task automatic get_frame(input int budget, output bit ok);
    int n = 0;
    while (words.size() < rd_ptr + 4 && n < budget) begin
      tick();
      n++;
    end
    ok = (words.size() >= rd_ptr + 4);
    if (ok) begin
      for (int i = 0; i < 4; i++) begin
        fw[i]  = words[rd_ptr + i];
        fl[i]  = lasts[rd_ptr + i];
        fcy[i] = wcyc[rd_ptr + i];
      end
      rd_ptr += 4;
    end
  endtask

  task automatic test_reset();
    do_reset();
    vecs++;
    if ({rdfifo_rden, out_valid, out_last, busy} !== 4'b0000 || out_dat !== 32'h0) begin
      errs++;
      $display("FAIL reset_outputs got rden/vld/last/busy=%b%b%b%b dat=%h exp 0000 dat=0",
               rdfifo_rden, out_valid, out_last, busy, out_dat);
    end
  endtask

  task automatic test_result();
    bit ok;
    int c, base;
    logic [31:0] v;
    v = 32'd25;
    base = rden_cyc.size();
    c = cyc;
    push(v);
    get_frame(50, ok);
    vecs++;
    if (!ok) begin errs++; $display("FAIL t1_timeout got no frame exp frame"); return; end
    vecs++;
    if (rden_cyc.size() - base !== 1 || rden_cyc[base] !== c) begin
      errs++;
      $display("FAIL t1_rden got %0d pulses first at %0d exp 1 at %0d",
               rden_cyc.size() - base, rden_cyc[base], c);
    end
    vecs++;
    if (fcy[0] !== c + 2 || fcy[3] !== c + 5) begin
      errs++;
      $display("FAIL t1_latency got hdr@%0d trl@%0d exp %0d/%0d", fcy[0], fcy[3], c + 2, c + 5);
    end
    vecs++;
    if (fw[0] !== 32'hA520_0000) begin
      errs++; $display("FAIL t1_header got %h exp a5200000", fw[0]);
    end
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (fw[i] !== exp_word(i, 2'b00, v, c, m_fc) || fl[i] !== (i == 3)) begin
        errs++;
        $display("FAIL t1_word%0d got %h last=%b exp %h last=%b", i, fw[i], fl[i],
                 exp_word(i, 2'b00, v, c, m_fc), (i == 3));
      end
    end
    m_fc++;
    v = -32'sd5;
    c = cyc;
    push(v);
    get_frame(50, ok);
    vecs++;
    if (!ok) begin errs++; $display("FAIL t2_timeout got no frame exp frame"); return; end
    vecs++;
    if (fw[0] !== 32'hA500_0001 || fw[2] !== 32'hFFFF_FFFB) begin
      errs++; $display("FAIL t2_hdr_pay got %h/%h exp a5000001/fffffffb", fw[0], fw[2]);
    end
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (fw[i] !== exp_word(i, 2'b00, v, c, m_fc) || fl[i] !== (i == 3)) begin
        errs++;
        $display("FAIL t2_word%0d got %h last=%b exp %h", i, fw[i], fl[i],
                 exp_word(i, 2'b00, v, c, m_fc));
      end
    end
    m_fc++;
  endtask

  task automatic test_heartbeat();
    bit ok;
    int base;
    logic [31:0] v;
    do_reset();
    get_frame(HBP + 50, ok);
    vecs++;
    if (!ok) begin errs++; $display("FAIL t3_hb_timeout got no frame exp heartbeat"); return; end
    vecs++;
    if (fcy[0] !== HBP || fw[0] !== 32'hA540_0000) begin
      errs++; $display("FAIL t3_hb_hdr got %h@%0d exp a5400000@%0d", fw[0], fcy[0], HBP);
    end
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (fw[i] !== exp_word(i, 2'b01, 32'h0, HBP - 1, m_fc) || fl[i] !== (i == 3)) begin
        errs++;
        $display("FAIL t3_hb_word%0d got %h exp %h", i, fw[i],
                 exp_word(i, 2'b01, 32'h0, HBP - 1, m_fc));
      end
    end
    m_fc++;
    // Heartbeat occupies HBP..HBP+3; the next expiry lands HBP idle cycles later.
    while (cyc < 2 * HBP + 3) tick();
    base = rden_cyc.size();
    v = $urandom;
    push(v);
    get_frame(50, ok);
    vecs++;
    if (!ok) begin errs++; $display("FAIL t3_race_timeout got no frame exp result"); return; end
    vecs++;
    if (rden_cyc.size() <= base || rden_cyc[base] !== 2 * HBP + 3 || fcy[0] !== 2 * HBP + 5) begin
      errs++;
      $display("FAIL t3_race_timing got hdr@%0d exp rden@%0d hdr@%0d", fcy[0],
               2 * HBP + 3, 2 * HBP + 5);
    end
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (fw[i] !== exp_word(i, 2'b00, v, 2 * HBP + 3, m_fc)) begin
        errs++;
        $display("FAIL t3_race_word%0d got %h exp %h", i, fw[i],
                 exp_word(i, 2'b00, v, 2 * HBP + 3, m_fc));
      end
    end
    m_fc++;
  endtask

  task automatic test_backpressure();
    bit ok;
    int c, base, trl;
    logic [31:0] v1, v2;
    v1 = $urandom;
    v2 = $urandom;
    c = cyc;
    push(v1);
    while (cyc < c + 3) tick();
    out_ready = 1'b0;
    push(v2);
    base = rden_cyc.size();
    for (int k = 0; k < 5; k++) begin
      vecs++;
      if (out_valid !== 1'b1 || out_dat !== c || rdfifo_rden !== 1'b0) begin
        errs++;
        $display("FAIL t4_stall%0d got vld=%b dat=%h rden=%b exp 1/%h/0", k, out_valid,
                 out_dat, rdfifo_rden, c);
      end
      tick();
    end
    out_ready = 1'b1;
    get_frame(50, ok);
    vecs++;
    if (!ok) begin errs++; $display("FAIL t4_timeout1 got no frame exp frame"); return; end
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (fw[i] !== exp_word(i, 2'b00, v1, c, m_fc)) begin
        errs++;
        $display("FAIL t4_f1_word%0d got %h exp %h", i, fw[i], exp_word(i, 2'b00, v1, c, m_fc));
      end
    end
    m_fc++;
    trl = fcy[3];
    get_frame(50, ok);
    vecs++;
    if (!ok) begin errs++; $display("FAIL t4_timeout2 got no frame exp frame"); return; end
    vecs++;
    if (rden_cyc.size() - base !== 1 || rden_cyc[base] !== trl + 1) begin
      errs++;
      $display("FAIL t4_rden_after_trl got %0d pulses first@%0d exp 1@%0d",
               rden_cyc.size() - base, rden_cyc[base], trl + 1);
    end
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (fw[i] !== exp_word(i, 2'b00, v2, trl + 1, m_fc)) begin
        errs++;
        $display("FAIL t4_f2_word%0d got %h exp %h", i, fw[i],
                 exp_word(i, 2'b00, v2, trl + 1, m_fc));
      end
    end
    m_fc++;
  endtask

  task automatic test_wrap();
    bit ok;
    logic [31:0] bnd[5];
    logic [31:0] pay[17];
    bnd = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    do_reset();
    for (int k = 0; k < 17; k++) begin
      pay[k] = (k < 5) ? bnd[k] : $urandom;
      push(pay[k]);
    end
    for (int k = 0; k < 17; k++) begin
      get_frame(50, ok);
      vecs++;
      if (!ok) begin errs++; $display("FAIL t5_timeout%0d got no frame exp frame", k); return; end
      for (int i = 0; i < 4; i++) begin
        vecs++;
        if (fw[i] !== exp_word(i, 2'b00, pay[k], 6 * k, m_fc) || fl[i] !== (i == 3)) begin
          errs++;
          $display("FAIL t5_f%0d_word%0d got %h exp %h", k, i, fw[i],
                   exp_word(i, 2'b00, pay[k], 6 * k, m_fc));
        end
      end
      m_fc++;
    end
    vecs++;
    if (fw[0][15:0] !== 16'h0000) begin
      errs++; $display("FAIL t5_wrap got %h exp 0000", fw[0][15:0]);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int c, base;
    logic [31:0] v;
    c = cyc;
    push($urandom);
    while (cyc < c + 4) tick();
    rst = 1'b1;
    tick();
    vecs++;
    if (out_valid !== 1'b0 || rdfifo_rden !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL t6_after_rst got vld=%b rden=%b busy=%b exp 000", out_valid, rdfifo_rden, busy);
    end
    rst = 1'b0;
    m_fc = 0;
    rd_ptr = words.size();
    base = rden_cyc.size();
    repeat (10) tick();
    vecs++;
    if (rden_cyc.size() !== base || words.size() !== rd_ptr) begin
      errs++;
      $display("FAIL t6_stray got %0d rden %0d words exp 0/0", rden_cyc.size() - base,
               words.size() - rd_ptr);
    end
    v = $urandom;
    c = cyc;
    push(v);
    get_frame(50, ok);
    vecs++;
    if (!ok) begin errs++; $display("FAIL t6_timeout got no frame exp frame"); return; end
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (fw[i] !== exp_word(i, 2'b00, v, c, m_fc)) begin
        errs++;
        $display("FAIL t6_word%0d got %h exp %h", i, fw[i], exp_word(i, 2'b00, v, c, m_fc));
      end
    end
    m_fc++;
  endtask

  task automatic test_random_stall();
    bit ok;
    int base;
    logic [31:0] pay[10];
    base = rden_cyc.size();
    rnd_mode = 1'b1;
    for (int k = 0; k < 10; k++) begin
      pay[k] = $urandom;
      push(pay[k]);
    end
    for (int k = 0; k < 10; k++) begin
      get_frame(200, ok);
      vecs++;
      if (!ok || rden_cyc.size() <= base + k) begin
        errs++; $display("FAIL t7_timeout%0d got no frame exp frame", k); break;
      end
      for (int i = 0; i < 4; i++) begin
        vecs++;
        if (fw[i] !== exp_word(i, 2'b00, pay[k], rden_cyc[base + k], m_fc) || fl[i] !== (i == 3)) begin
          errs++;
          $display("FAIL t7_f%0d_word%0d got %h exp %h", k, i, fw[i],
                   exp_word(i, 2'b00, pay[k], rden_cyc[base + k], m_fc));
        end
      end
      m_fc++;
    end
    rnd_mode = 1'b0;
    out_ready = 1'b1;
    vecs++;
    if (viol !== 0) begin
      errs++; $display("FAIL protocol got %0d violations exp 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_result();
    test_heartbeat();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_random_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
